sync_fifo: RTL and testbench

- Single-clock, first-word-fall-through FIFO.
- Its storage and pointer/count state are built from enable-gated registers, equivalent to the codebase FF cell.
- Serves as the reference buffer under the data-integrity scoreboard. The scoreboard tracks a "magic packet" through the queue and compares it against data_out on the cycle the packet is popped.
- Must preserve strict in-order delivery of every accepted word.

---
 rtl/sync_fifo.sv | 95 +++++++++
 tb/tb_sync_fifo.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
// Storage, pointers and occupancy count are enable-gated registers.
// The head entry is presented combinationally on data_out; full/empty are
// decoded straight from the stored count, so flags carry no extra latency.
module sync_fifo #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int PTRWID = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] data_out
);

  localparam logic [PTRWID:0] FULL_CNT = (PTRWID+1)'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d;
  logic [DEPTH-1:0]  mem_en;

  logic [PTRWID-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRWID-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTRWID:0]   count_q, count_d;

  logic push_ok, pop_ok, count_en;

  // Flags and head word are pure decodes of the registered state.
  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign data_out = mem_q[rd_ptr_q];

  // Acceptance from pre-edge flags, next-state values and register enables.
  always_comb begin
    push_ok  = push & ~full;
    pop_ok   = pop & ~empty;
    mem_d    = data_in;
    wr_ptr_d = wr_ptr_q + 1'b1;
    rd_ptr_d = rd_ptr_q + 1'b1;
    // Count only moves when exactly one side is accepted.
    count_en = push_ok ^ pop_ok;
    count_d  = push_ok ? (count_q + 1'b1) : (count_q - 1'b1);
    mem_en   = '0;
    if (push_ok) begin
      mem_en[wr_ptr_q] = 1'b1;
    end
  end

  // Write pointer advances on every accepted push, wrapping naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
    end else if (push_ok) begin
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Read pointer advances on every accepted pop; storage is left intact.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
    end else if (pop_ok) begin
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Occupancy count, held when push and pop are both or neither accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (count_en) begin
      count_q <= count_d;
    end
  end

  // Storage entries, each written only when selected by an accepted push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (mem_en[i]) begin
          mem_q[i] <= mem_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed and random-legal traffic against a queue model.
module tb_sync_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  logic             clk;
  logic             rst;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] data_in;
  logic             full;
  logic             empty;
  logic [WIDTH-1:0] data_out;

  int vectors     = 0;
  int miscompares = 0;

  logic [WIDTH-1:0] mq [$];

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .data_in  (data_in),
    .full     (full),
    .empty    (empty),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue with the acceptance rules.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
    end else if (push && pop && mq.size() > 0 && mq.size() < DEPTH) begin
      void'(mq.pop_front());
      mq.push_back(data_in);
    end else if (pop && mq.size() > 0) begin
      void'(mq.pop_front());
    end else if (push && mq.size() < DEPTH) begin
      mq.push_back(data_in);
    end
  end

  // Every-cycle comparison of flags and head word against the model.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      chk("empty_vs_model", 32'(empty), 32'(mq.size() == 0));
      chk("full_vs_model",  32'(full),  32'(mq.size() == DEPTH));
      if (mq.size() > 0) begin
        chk("head_vs_model", 32'(data_out), 32'(mq[0]));
      end
    end
  end

  // Apply one cycle of stimulus starting at a falling edge.
  task automatic step(input logic ph, input logic pp, input logic [WIDTH-1:0] d);
    push    = ph;
    pop     = pp;
    data_in = d;
    @(posedge clk);
    @(negedge clk);
    push    = 1'b0;
    pop     = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic             ph, pp;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] magic_val;
    int               pushed, popped;
    int               magic_idx;

    rst = 1'b0; push = 1'b0; pop = 1'b0; data_in = '0;
    magic_val = '0;
    #12;
    chk("por_empty", 32'(empty), 32'd1);
    chk("por_full",  32'(full),  32'd0);
    chk("por_dout",  32'(data_out), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Mid-stream asynchronous reset with three entries stored.
    step(1'b1, 1'b0, 8'hA1);
    step(1'b1, 1'b0, 8'hA2);
    step(1'b1, 1'b0, 8'hA3);
    chk("pre_rst_head", 32'(data_out), 32'hA1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full),  32'd0);
    chk("rst_dout",  32'(data_out), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 1'b0, 8'h11);
    chk("post_rst_dout", 32'(data_out), 32'h11);
    step(1'b0, 1'b1, 8'h00);
    chk("post_rst_drain_empty", 32'(empty), 32'd1);

    // Fill to full, push while full is ignored, then drain in order.
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b1, 1'b0, 8'(i));
    end
    chk("fill_full", 32'(full), 32'd1);
    step(1'b1, 1'b0, 8'hFF);
    chk("ovf_full", 32'(full), 32'd1);
    for (int i = 1; i <= DEPTH; i++) begin
      chk("drain_order", 32'(data_out), 32'(i));
      step(1'b0, 1'b1, 8'h00);
    end
    chk("drain_empty", 32'(empty), 32'd1);

    // Pop while empty is ignored; a following push appears at the head.
    step(1'b0, 1'b1, 8'h00);
    chk("udf_empty", 32'(empty), 32'd1);
    step(1'b1, 1'b0, 8'h22);
    chk("udf_push_dout", 32'(data_out), 32'h22);
    step(1'b0, 1'b1, 8'h00);

    // Push+pop at empty: only the push lands.
    step(1'b1, 1'b1, 8'h33);
    chk("emp_pp_empty", 32'(empty), 32'd0);
    chk("emp_pp_dout",  32'(data_out), 32'h33);
    step(1'b1, 1'b0, 8'h34);
    step(1'b1, 1'b0, 8'h35);
    step(1'b1, 1'b0, 8'h36);
    // Simultaneous push+pop at occupancy 4.
    for (int i = 0; i < 3; i++) begin
      chk("sim_pop_order", 32'(data_out), 32'(8'h33 + i));
      step(1'b1, 1'b1, 8'(8'hA0 + i));
    end
    chk("sim_not_full",  32'(full),  32'd0);
    chk("sim_not_empty", 32'(empty), 32'd0);
    chk("sim_drain0", 32'(data_out), 32'h36); step(1'b0, 1'b1, 8'h00);
    chk("sim_drain1", 32'(data_out), 32'hA0); step(1'b0, 1'b1, 8'h00);
    chk("sim_drain2", 32'(data_out), 32'hA1); step(1'b0, 1'b1, 8'h00);
    chk("sim_drain3", 32'(data_out), 32'hA2); step(1'b0, 1'b1, 8'h00);
    chk("sim_drained", 32'(empty), 32'd1);

    // Push+pop at full: only the pop lands, leaving seven entries.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, 8'(8'h40 + i));
    end
    chk("full_pp_pre", 32'(full), 32'd1);
    step(1'b1, 1'b1, 8'h50);
    chk("full_pp_full", 32'(full), 32'd0);
    for (int i = 1; i < DEPTH; i++) begin
      chk("full_pp_drain", 32'(data_out), 32'(8'h40 + i));
      step(1'b0, 1'b1, 8'h00);
    end
    chk("full_pp_empty", 32'(empty), 32'd1);

    // Wrap-around at occupancy 3 with words 0x00..0x13.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 8'(i));
    end
    for (int i = 3; i < 20; i++) begin
      chk("wrap_order", 32'(data_out), 32'(i - 3));
      step(1'b1, 1'b1, 8'(i));
    end
    for (int i = 17; i < 20; i++) begin
      chk("wrap_tail", 32'(data_out), 32'(i));
      step(1'b0, 1'b1, 8'h00);
    end
    chk("wrap_empty", 32'(empty), 32'd1);

    // Magic packet under random legal traffic.
    pushed = 0; popped = 0; magic_idx = 15;
    for (int c = 0; c < 300; c++) begin
      ph = 1'b0; pp = 1'b0;
      if ($urandom_range(0, 1) == 1 && mq.size() < DEPTH) ph = 1'b1;
      if ($urandom_range(0, 1) == 1 && mq.size() > 0) pp = 1'b1;
      d = 8'($urandom);
      if (ph && pushed == magic_idx) magic_val = d;
      if (pp && popped == magic_idx) chk("magic_packet", 32'(data_out), 32'(magic_val));
      if (ph) pushed++;
      if (pp) popped++;
      step(ph, pp, d);
    end
    for (int c = 0; c < DEPTH && mq.size() > 0; c++) begin
      if (popped == magic_idx) chk("magic_packet", 32'(data_out), 32'(magic_val));
      popped++;
      step(1'b0, 1'b1, 8'h00);
    end
    chk("magic_seen", 32'(popped > magic_idx), 32'd1);
    chk("final_empty", 32'(empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
